// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Access width codes; SZ_LOAD only appears on the store_size input and is
  // resolved to a real width from funct3 before it reaches the datapath.
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_LOAD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Resolve the effective access width; unknown load funct3 codes act as LW.
  function automatic logic [1:0] decodeSize(input logic [1:0] storeSize,
                                            input logic [2:0] f3);
    logic [1:0] sz;
    if (storeSize != SZ_LOAD) begin
      sz = storeSize;
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  // Only LB and LH sign-extend; stores never use the signedness.
  function automatic logic decodeSigned(input logic [1:0] storeSize,
                                        input logic [2:0] f3);
    return (storeSize == SZ_LOAD) && ((f3 == F3_LB) || (f3 == F3_LH));
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane logic: store steering, alignment check, load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  // Steer store data onto the byte lanes and flag natural-alignment violations.
  always_comb begin
    wstrb_o      = 4'b1111;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        wstrb_o      = 4'b0011 << offset_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = offset_i[0];
      end
      default: begin
        wstrb_o      = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = (offset_i != 2'b00);
      end
    endcase
  end

  // Bring the addressed bytes down to bit 0 and extend to the full word.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_B:    load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one outstanding bus access, pipeline stall,
// timeout abort and extended load return to writeback.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        memory_en,
  input  logic [1:0]  store_size,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic [31:0]      load_data_q;
  logic             load_valid_q;
  logic             bus_timeout_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [1:0]       offset_q;

  logic [1:0]  reqSize;
  logic        reqSigned;
  logic        reqIsStore;
  logic        inIdle;
  logic        accept;
  logic [1:0]  alSize;
  logic        alSigned;
  logic [1:0]  alOffset;
  logic [3:0]  alWstrb;
  logic [31:0] alWdata;
  logic        alMisaligned;
  logic [31:0] alLoadData;

  // Decode the incoming instruction; the lane logic sees it only while idle,
  // afterwards it sees the captured access so load extraction matches the request.
  always_comb begin
    reqSize    = decodeSize(store_size, funct3);
    reqSigned  = decodeSigned(store_size, funct3);
    reqIsStore = (store_size != SZ_LOAD);
    inIdle     = (state_q == IDLE);
    alSize     = inIdle ? reqSize   : size_q;
    alSigned   = inIdle ? reqSigned : signed_q;
    alOffset   = inIdle ? addr[1:0] : offset_q;
    accept     = memory_en & inIdle & ~alMisaligned;
  end

  lsu_align u_align (
    .size_i       (alSize),
    .signed_i     (alSigned),
    .offset_i     (alOffset),
    .store_data_i (store_data),
    .rdata_i      (mem_rdata),
    .wstrb_o      (alWstrb),
    .wdata_o      (alWdata),
    .misaligned_o (alMisaligned),
    .load_data_o  (alLoadData)
  );

  // Access FSM with timeout counter and registered bus/result outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      load_data_q   <= '0;
      load_valid_q  <= 1'b0;
      bus_timeout_q <= 1'b0;
      size_q        <= SZ_B;
      signed_q      <= 1'b0;
      offset_q      <= 2'b00;
    end else begin
      load_valid_q  <= 1'b0;
      bus_timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= reqIsStore;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_wdata_q <= alWdata;
            mem_wstrb_q <= reqIsStore ? alWstrb : 4'b0000;
            size_q      <= reqSize;
            signed_q    <= reqSigned;
            offset_q    <= addr[1:0];
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_q   <= DONE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              load_data_q  <= alLoadData;
              load_valid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= DONE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            bus_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign bus_timeout = bus_timeout_q;
  assign misaligned  = memory_en & inIdle & alMisaligned;
  assign stall       = accept | (state_q == BUSY);

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit of the memory stage. Sits directly downstream of the instruction controller.
- Consumes the controller's memory_en and store_size together with the ALU address, rs2 data and funct3.
- Runs a single-outstanding request/ready transaction on the 32-bit data bus and stalls the pipeline until the transaction completes.
- Returns sign- or zero-extended load data to the writeback mux (wdSelect 2'b01 path).

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of BUSY cycles without mem_ready before the access is aborted.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memory_en  in  1  the current instruction accesses memory.
- store_size  in  2  00 byte, 01 half, 10 word store; 11 means load.
- funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr  in  32  byte address from the ALU.
- store_data  in  32  rs2 value.
- mem_req  out  1  bus request; held high until mem_ready or timeout.
- mem_we  out  1  1 for store, 0 for load.
- mem_addr  out  32  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-steered store data.
- mem_wstrb  out  4  byte-lane write enables; 0000 on loads.
- mem_ready  in  1  bus completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.
- stall  out  1  freezes the upstream pipeline.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse with load_data.
- misaligned  out  1  combinational alignment fault flag.
- bus_timeout  out  1  one-cycle pulse when an access was aborted.

Behaviour:
- Reset values: state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, load_data 0, load_valid 0, bus_timeout 0. The reset is synchronous; a reset asserted mid-transaction drops mem_req at the next edge and discards the access.
- Size: store_size 00/01/10 selects byte/half/word. For store_size 11 (load) the width comes from funct3. funct3 011/110/111 on a load is treated as LW.
- Alignment is combinational in IDLE:
  - half requires addr[0]=0;
  - word requires addr[1:0]=00;
  - misaligned = memory_en & IDLE & violation.
  - A misaligned access issues no bus access, raises no stall and leaves state unchanged.
- FSM state IDLE:
  - memory_en & ~violation: register addr, size, signedness, we and steered data; go to BUSY.
  - Otherwise stay in IDLE.
- FSM state BUSY:
  - mem_req=1; all bus outputs stay stable.
  - Counter increments each cycle.
  - mem_ready: capture the extended load into load_data and go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_ready: go to DONE with timeout flagged.
- FSM state DONE:
  - mem_req=0.
  - load_valid=1 if the access was a load and did not time out; bus_timeout=1 if it timed out.
  - Always return to IDLE. memory_en is ignored in DONE, because this is the same instruction now leaving the stage.
- stall = (IDLE & memory_en & ~violation) | BUSY. stall is deasserted in DONE.
- Latency:
  - Zero-wait memory: accept in IDLE (cycle 0), request in BUSY (cycle 1), DONE (cycle 2). Two stall cycles.
  - Each wait state adds one cycle.
- Write steering:
  - byte: wstrb = 0001 << addr[1:0], data replicated x4.
  - half: wstrb = 0011 << addr[1:0], data replicated x2.
  - word: wstrb = 1111.
- Load extraction:
  - Shift rdata right by 8*addr[1:0], take 8/16/32 bits.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Back-to-back accesses: the next instruction reaches the stage in IDLE the cycle after DONE. There is no bubble beyond that.
- mem_ready while not in BUSY is ignored.
- When the counter expires and mem_ready arrives in the same cycle, mem_ready wins: the access completes normally.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_t enum {IDLE, BUSY, DONE};
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_LOAD=2'b11;
  - load funct3 constants F3_LB/LH/LW/LBU/LHU.
- One combinational sub-module, lsu_align, produces wstrb, the steered wdata, the misalignment flag and the extended load_data from (size, signed, addr[1:0], store_data, rdata).
- The FSM, timeout counter and output registers stay in lsu_mem_stage.

Test Plan:
- Byte store: SB, addr=0x1003, store_data=0x000000A5, mem_ready on the first BUSY cycle -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, mem_we=1, stall high for exactly 2 cycles.
- Signed halfword load: LH, addr=0x2002, rdata=0x8001_1234 -> load_data=0xFFFF8001, load_valid pulses in DONE. The same access with LHU -> 0x00008001.
- Misaligned access: LW addr=0x3001 -> misaligned=1 the same cycle, mem_req never asserted, stall=0. Also check SH addr=0x3003.
- Wait states and timeout:
  - LW with mem_ready after 3 wait cycles -> stall for 5 cycles, mem_req held with stable addr.
  - No mem_ready -> bus_timeout pulses after 16 BUSY cycles, load_valid=0.
- Back-to-back and reset:
  - SW at 0x10 followed immediately by LW at 0x10 -> second request issues the cycle after DONE.
  - reset asserted in BUSY -> mem_req=0 and state IDLE at the next edge.
